// File: rtl/fifo_rd_port_if.sv
// Stream interface carrying FIFO words from the read-side controller to the
// consumer.
//   data_out  : head word presented to the consumer
//   valid_out : data_out holds an unread word
//   ready_in  : consumer accepts data_out this cycle
// master: the FIFO read port (drives data/valid); slave: the consumer.
interface fifo_rd_port_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic             ready_in;

  modport master (
    output data_out,
    output valid_out,
    input  ready_in
  );

  modport slave (
    input  data_out,
    input  valid_out,
    output ready_in
  );
endinterface

// File: rtl/fifo_rd_port.sv
// Read-side controller for the 4096-bit dual-port block RAM used as FIFO
// storage. Compares its read pointer with the writer's pointer, issues RAM
// reads, absorbs the one-cycle RAM read latency in a two-entry output buffer
// (head + skid) and presents words in FIFO order on a valid/ready stream.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_ptr     : writer pointer (MSB is the wrap bit)
//   flush      : synchronous discard of all unread words
//   rd_ptr     : read pointer (words issued to RAM), returned to the writer
//   mem_addr   : RAM read address (low bits of rd_ptr)
//   mem_data   : RAM read data, valid one cycle after mem_addr is sampled
//   strm       : output stream (data_out / valid_out / ready_in)
module fifo_rd_port #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned DEPTH = 4096 / WIDTH,
  localparam int unsigned ADDRW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ADDRW:0]   wr_ptr,
  input  logic             flush,
  output logic [ADDRW:0]   rd_ptr,
  output logic [ADDRW-1:0] mem_addr,
  input  logic [WIDTH-1:0] mem_data,
  fifo_rd_port_if.master   strm
);

  logic [ADDRW:0]   rd_ptr_q, rd_ptr_d;
  logic             pending_q, pending_d;
  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] skid_q, skid_d;

  logic       empty;
  logic       pop;
  logic       issue;
  logic [2:0] occ;
  logic [1:0] remain;

  assign empty  = (rd_ptr_q == wr_ptr);
  assign pop    = (count_q != 2'd0) && strm.ready_in;
  // Words held or in flight once this cycle's pop is taken; issuing only when
  // this is at most one keeps count + pending within the two buffer entries.
  assign occ    = {1'b0, count_q} + {2'b00, pending_q} - {2'b00, pop};
  assign remain = count_q - {1'b0, pop};
  assign issue  = !empty && !flush && (occ <= 3'd1);

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    pending_d = issue;
    count_d   = remain + {1'b0, pending_q};
    head_d    = head_q;
    skid_d    = skid_q;

    if (pop && (count_q == 2'd2)) begin
      head_d = skid_q;
    end

    if (pending_q) begin
      // Returning word goes to head if the buffer drains this cycle.
      if (remain == 2'd0) begin
        head_d = mem_data;
      end else begin
        skid_d = mem_data;
      end
    end

    if (issue) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    if (flush) begin
      // In-flight data and any same-cycle writes are discarded.
      rd_ptr_d  = wr_ptr;
      pending_d = 1'b0;
      count_d   = 2'd0;
      head_d    = head_q;
      skid_d    = skid_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q  <= '0;
      pending_q <= 1'b0;
      count_q   <= 2'd0;
      head_q    <= '0;
      skid_q    <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      pending_q <= pending_d;
      count_q   <= count_d;
      head_q    <= head_d;
      skid_q    <= skid_d;
    end
  end

  assign rd_ptr         = rd_ptr_q;
  assign mem_addr       = rd_ptr_q[ADDRW-1:0];
  assign strm.data_out  = head_q;
  assign strm.valid_out = (count_q != 2'd0);

endmodule

// File: tb/tb_fifo_rd_port.sv
// Testbench for fifo_rd_port: models the write side and a registered-read
// RAM, applies a table of per-cycle vectors and several multi-cycle sequences
// (streaming with wrap, mid-stream reset, full interplay).
module tb_fifo_rd_port;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned ADDRW = 9;

  logic             clk;
  logic             rst_n;
  logic [ADDRW:0]   wr_ptr;
  logic             flush;
  logic [ADDRW:0]   rd_ptr;
  logic [ADDRW-1:0] mem_addr;
  logic [WIDTH-1:0] mem_data;
  logic [WIDTH-1:0] ram [512];

  fifo_rd_port_if #(.WIDTH(WIDTH)) strm_if ();

  fifo_rd_port #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_ptr   (wr_ptr),
    .flush    (flush),
    .rd_ptr   (rd_ptr),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .strm     (strm_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read RAM.
  always @(posedge clk) mem_data <= ram[mem_addr];

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic wr_word(input logic [7:0] d);
    ram[wr_ptr[ADDRW-1:0]] = d;
    wr_ptr = wr_ptr + 1'b1;
  endtask

  function automatic logic is_full(input logic [ADDRW:0] w, input logic [ADDRW:0] r);
    return (w[ADDRW] != r[ADDRW]) && (w[ADDRW-1:0] == r[ADDRW-1:0]);
  endfunction

  typedef struct {
    logic       wr;
    logic [7:0] wdata;
    logic       ready;
    logic       flush;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [9:0] exp_rd;
  } vec_t;

  vec_t vecs [24];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] q [$];
    logic [7:0] exp_w;
    logic [9:0] prev_rd, nxt_rd;
    logic [8:0] prev_addr;
    logic       started, ended, gap, wrap_rd, wrap_addr, step_err, seen, full;
    int         got;
    int         n_stream;

    //           wr  wdata  rdy flush ev  edata  erd
    vecs[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 10'd1};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 10'd1};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 10'd1};
    vecs[3]  = '{1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 8'h00, 10'd2};
    vecs[4]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 8'h10, 10'd3};
    vecs[5]  = '{1'b1, 8'h12, 1'b0, 1'b0, 1'b1, 8'h10, 10'd3};
    vecs[6]  = '{1'b1, 8'h13, 1'b0, 1'b0, 1'b1, 8'h10, 10'd3};
    vecs[7]  = '{1'b1, 8'h14, 1'b0, 1'b0, 1'b1, 8'h10, 10'd3};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h11, 10'd4};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 10'd4};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h12, 10'd5};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h12, 10'd5};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h13, 10'd6};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h13, 10'd6};
    vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h14, 10'd6};
    vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h14, 10'd6};
    vecs[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 10'd6};
    vecs[17] = '{1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 8'h00, 10'd7};
    vecs[18] = '{1'b1, 8'h21, 1'b0, 1'b0, 1'b1, 8'h20, 10'd8};
    vecs[19] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'h00, 10'd9};
    vecs[20] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 10'd9};
    vecs[21] = '{1'b1, 8'h30, 1'b1, 1'b0, 1'b0, 8'h00, 10'd10};
    vecs[22] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h30, 10'd10};
    vecs[23] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 10'd10};

    for (int i = 0; i < 512; i++) ram[i] = 8'hEE;
    rst_n = 1'b0;
    wr_ptr = '0;
    flush = 1'b0;
    strm_if.ready_in = 1'b0;

    // Reset state.
    #23;
    check("rst_valid", {31'd0, strm_if.valid_out}, 32'd0);
    check("rst_data", {24'd0, strm_if.data_out}, 32'd0);
    check("rst_rd_ptr", {22'd0, rd_ptr}, 32'd0);
    check("rst_mem_addr", {23'd0, mem_addr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Per-cycle vectors: single word, backpressure, flush with read in flight.
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (vecs[i].wr) wr_word(vecs[i].wdata);
      strm_if.ready_in = vecs[i].ready;
      flush = vecs[i].flush;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_valid", i), {31'd0, strm_if.valid_out}, {31'd0, vecs[i].exp_valid});
      if (vecs[i].exp_valid)
        check($sformatf("v%0d_data", i), {24'd0, strm_if.data_out}, {24'd0, vecs[i].exp_data});
      check($sformatf("v%0d_rd_ptr", i), {22'd0, rd_ptr}, {22'd0, vecs[i].exp_rd});
      check($sformatf("v%0d_mem_addr", i), {23'd0, mem_addr}, {23'd0, vecs[i].exp_rd[8:0]});
    end
    @(negedge clk);
    flush = 1'b0;

    // Streaming with ready high, crossing both address and pointer wraps.
    n_stream = 1100;
    got = 0;
    started = 1'b0; ended = 1'b0; gap = 1'b0;
    wrap_rd = 1'b0; wrap_addr = 1'b0; step_err = 1'b0;
    prev_rd = rd_ptr;
    prev_addr = mem_addr;
    for (int c = 0; c < n_stream + 20; c++) begin
      @(negedge clk);
      if (c < n_stream) begin
        wr_word(c[7:0]);
        q.push_back(c[7:0]);
      end
      strm_if.ready_in = 1'b1;
      @(posedge clk);
      #1;
      if (strm_if.valid_out) begin
        if (ended) gap = 1'b1;
        started = 1'b1;
        got++;
        if (q.size() > 0) begin
          exp_w = q.pop_front();
          check("stream_data", {24'd0, strm_if.data_out}, {24'd0, exp_w});
        end
      end else if (started) begin
        ended = 1'b1;
      end
      nxt_rd = prev_rd + 10'd1;
      if (prev_rd == 10'd1023 && rd_ptr == 10'd0) wrap_rd = 1'b1;
      if (prev_addr == 9'd511 && mem_addr == 9'd0) wrap_addr = 1'b1;
      if (rd_ptr != prev_rd && rd_ptr != nxt_rd) step_err = 1'b1;
      prev_rd = rd_ptr;
      prev_addr = mem_addr;
    end
    check("stream_count", got, n_stream);
    check("stream_no_gap", {31'd0, gap}, 32'd0);
    check("stream_rd_wrap", {31'd0, wrap_rd}, 32'd1);
    check("stream_addr_wrap", {31'd0, wrap_addr}, 32'd1);
    check("stream_rd_step", {31'd0, step_err}, 32'd0);
    check("stream_rd_final", {22'd0, rd_ptr}, {22'd0, wr_ptr});

    // Asynchronous reset while a word is presented.
    @(negedge clk);
    strm_if.ready_in = 1'b0;
    wr_word(8'h77);
    wr_word(8'h78);
    wr_word(8'h79);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (strm_if.valid_out) seen = 1'b1;
    end
    check("mid_rst_setup_valid", {31'd0, seen}, 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, strm_if.valid_out}, 32'd0);
    check("mid_rst_data", {24'd0, strm_if.data_out}, 32'd0);
    check("mid_rst_rd_ptr", {22'd0, rd_ptr}, 32'd0);
    check("mid_rst_mem_addr", {23'd0, mem_addr}, 32'd0);
    wr_ptr = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_rst_valid_%0d", c), {31'd0, strm_if.valid_out}, 32'd0);
      check($sformatf("post_rst_rd_ptr_%0d", c), {22'd0, rd_ptr}, 32'd0);
    end

    // Fill to full with the consumer stalled, then free one slot.
    full = 1'b0;
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      full = is_full(wr_ptr, rd_ptr);
      if (full) break;
      wr_word(c[7:0] ^ 8'h5A);
    end
    check("full_reached", {31'd0, full}, 32'd1);
    check("full_rd_ptr", {22'd0, rd_ptr}, 32'd2);
    check("full_wr_ptr", {22'd0, wr_ptr}, 32'd514);
    check("full_valid", {31'd0, strm_if.valid_out}, 32'd1);
    check("full_data", {24'd0, strm_if.data_out}, 32'h5A);
    strm_if.ready_in = 1'b1;
    @(posedge clk);
    #1;
    check("pop1_rd_ptr", {22'd0, rd_ptr}, 32'd3);
    check("pop1_valid", {31'd0, strm_if.valid_out}, 32'd1);
    check("pop1_data", {24'd0, strm_if.data_out}, 32'h5B);
    @(negedge clk);
    strm_if.ready_in = 1'b0;
    check("pop1_not_full", {31'd0, is_full(wr_ptr, rd_ptr)}, 32'd0);
    wr_word(8'hC3);
    @(posedge clk);
    #1;
    check("refill_rd_ptr", {22'd0, rd_ptr}, 32'd3);
    @(negedge clk);
    check("refill_full", {31'd0, is_full(wr_ptr, rd_ptr)}, 32'd1);
    check("refill_data", {24'd0, strm_if.data_out}, 32'h5B);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
